vga_fill_ctrl: RTL and testbench
================================

Name: vga_fill_ctrl

Overview:
- APB-programmable rectangle-fill sequencer for the VGA pixel-write port (x, y, color, we) of the frame-buffer datapath.
- Software programs origin, size and color, then writes START.
- Block clips the rectangle to the screen and emits one pixel write per accepted handshake in raster order (x inner, y outer).
- Sits between the APB bus and the VGA memory wrapper; owns the pixel-write port while busy.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- APB_DATA_WIDTH, 32, APB data width.
- COORD_W, 11, coordinate and size width.
- COLOR_W, 2, pixel color width.
- H_RES, 640, horizontal pixels; valid x is 0..H_RES-1.
- V_RES, 480, vertical lines; valid y is 0..V_RES-1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- apb_paddr_i  in  APB_ADDR_WIDTH  APB address
- apb_pwdata_i  in  APB_DATA_WIDTH  APB write data
- apb_pwrite_i  in  1  APB write
- apb_psel_i  in  1  APB select
- apb_penable_i  in  1  APB enable
- apb_prdata_o  out  APB_DATA_WIDTH  APB read data
- apb_pready_o  out  1  APB ready
- apb_pslverr_o  out  1  APB error
- pix_x_o  out  COORD_W  pixel x
- pix_y_o  out  COORD_W  pixel y
- pix_color_o  out  COLOR_W  pixel color
- pix_we_o  out  1  pixel write request
- pix_ready_i  in  1  pixel sink accepts; transfer = pix_we_o & pix_ready_i
- busy_o  out  1  fill in progress

Behaviour:
- Reset: all registers, state=IDLE, every output 0.
- APB timing: apb_pready_o = 1 for exactly one cycle, the cycle after psel&penable first seen (one wait state), then 0. Completion = psel&penable&pready.
- Register writes and read-data capture take effect at the completion edge. apb_prdata_o is valid while pready=1, else 0. Unmapped read returns 0; unmapped write is ignored with pslverr=0.
- Register map (byte addresses):
  - 0x00 X0 [10:0]
  - 0x04 Y0 [10:0]
  - 0x08 WIDTH [10:0]
  - 0x0C HEIGHT [10:0]
  - 0x10 COLOR [1:0]
  - 0x14 CTRL: write bit0=START, bit1=ABORT; read {30'b0, done, busy}
  - 0x18 COUNT, read-only: pixels written in the current/last fill, 22 bits, zero-extended
- Writes to 0x00–0x10 while busy: ignored, pslverr=1 for that transfer.
- START while busy: ignored, pslverr=1. START and ABORT both set: ABORT wins.
- Clip, computed in CLIP state with COORD_W+1-bit arithmetic (no wrap):
  - xe = min(X0+WIDTH, H_RES); ye = min(Y0+HEIGHT, V_RES)
  - Empty when WIDTH=0, HEIGHT=0, X0>=H_RES or Y0>=V_RES.
- FSM:
  - IDLE: START → CLIP. On START: clear done, clear COUNT, latch geometry and color.
  - CLIP (1 cycle): empty → DONE; else cx=X0, cy=Y0 → FILL.
  - FILL: pix_we_o=1, pix_x_o=cx, pix_y_o=cy, pix_color_o=latched color.
    - On transfer: COUNT+1; if cx=xe-1 then cx=X0 and cy+1, else cx+1.
    - Transfer at cx=xe-1 and cy=ye-1 → DONE.
    - pix_we_o, x, y and color stay stable until a transfer occurs.
  - DONE (1 cycle): set sticky done → IDLE.
- Latency: first pix_we_o is asserted 2 cycles after the START completion edge (CLIP, then FILL). Unstalled throughput is one pixel per cycle.
- ABORT in CLIP/FILL: → IDLE next edge, pix_we_o=0 at once, done stays 0, COUNT holds pixels written so far. ABORT in IDLE: no effect.
- busy_o = 1 in CLIP and FILL.
- pix_x_o/pix_y_o/pix_color_o are 0 outside FILL.
- Reset mid-fill returns to IDLE with all outputs 0 immediately (asynchronous).

Optional Feature:
- Macro VGA_FILL_IRQ_EN.
- When defined:
  - Adds output irq_o (1 bit) = done & irq_enable.
  - Adds register 0x1C IRQ: bit0 irq_enable (R/W, reset 0); writing bit1=1 clears done.
  - irq_o is level-high until cleared or until the next START.
- When undefined: no irq_o port. 0x1C behaves as unmapped. done is cleared only by START.

Test Plan:
- X0=10, Y0=20, W=3, H=2, COLOR=2, START, pix_ready_i=1 → 6 writes: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), color 2, back-to-back. First write 2 cycles after START completion. CTRL reads 0x2, COUNT=6.
- X0=638, Y0=479, W=5, H=4 → clipped to (638,479),(639,479); COUNT=2, done=1.
- W=0, START → no pix_we_o; busy for 1 cycle; done=1; COUNT=0.
- pix_ready_i toggling 1/0 during 4x1 fill → x/y/color held stable while stalled; exactly 4 transfers, x=X0..X0+3.
- Write X0 and START while busy → pslverr=1 on both; geometry unchanged. ABORT after 3 transfers → busy_o=0 next cycle, done=0, COUNT=3.
- With VGA_FILL_IRQ_EN: irq_enable=1, 1x1 fill → irq_o rises the cycle after the DONE state. Write 0x1C bit1 → irq_o=0 after the completion edge.

Source files
------------

// File: rtl/vga_fill_ctrl.sv
// APB-programmed rectangle fill sequencer driving the VGA pixel-write port in raster order.
// Optional macro VGA_FILL_IRQ_EN adds irq_o and the IRQ register at 0x1C.
`timescale 1ns/1ps
module vga_fill_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int COORD_W        = 11,
    parameter int COLOR_W        = 2,
    parameter int H_RES          = 640,
    parameter int V_RES          = 480
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
    input  logic                      apb_pwrite_i,
    input  logic                      apb_psel_i,
    input  logic                      apb_penable_i,
    output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
    output logic                      apb_pready_o,
    output logic                      apb_pslverr_o,
    output logic [COORD_W-1:0]        pix_x_o,
    output logic [COORD_W-1:0]        pix_y_o,
    output logic [COLOR_W-1:0]        pix_color_o,
    output logic                      pix_we_o,
    input  logic                      pix_ready_i,
`ifdef VGA_FILL_IRQ_EN
    output logic                      irq_o,
`endif
    output logic                      busy_o
);
    localparam int CNT_W = 22;
    localparam logic [APB_ADDR_WIDTH-1:0] A_X0    = APB_ADDR_WIDTH'('h00);
    localparam logic [APB_ADDR_WIDTH-1:0] A_Y0    = APB_ADDR_WIDTH'('h04);
    localparam logic [APB_ADDR_WIDTH-1:0] A_W     = APB_ADDR_WIDTH'('h08);
    localparam logic [APB_ADDR_WIDTH-1:0] A_H     = APB_ADDR_WIDTH'('h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_COLOR = APB_ADDR_WIDTH'('h10);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL  = APB_ADDR_WIDTH'('h14);
    localparam logic [APB_ADDR_WIDTH-1:0] A_COUNT = APB_ADDR_WIDTH'('h18);
    localparam logic [COORD_W:0]          H_LIM   = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0]          V_LIM   = (COORD_W+1)'(V_RES);

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [COORD_W-1:0] r_x0, r_y0, r_w, r_h, r_lx0, r_ly0, r_lw, r_lh, r_cx, r_cy;
    logic [COLOR_W-1:0] r_color, r_lcolor;
    logic [COORD_W:0]   r_xe, r_ye;
    logic [CNT_W-1:0]   r_count;
    logic               r_done, r_pready;

    logic w_access, w_wr, w_busy, w_geom_addr, w_start_req, w_start_ok, w_abort_ok;
    logic w_xfer, w_last_x, w_last_y, w_empty, w_unused, w_irq_clr;
    logic [COORD_W:0] w_xsum, w_ysum, w_xe, w_ye;
    logic [APB_DATA_WIDTH-1:0] w_rdata;

    assign w_unused    = ^apb_pwdata_i[APB_DATA_WIDTH-1:COORD_W];
    assign w_access    = apb_psel_i & apb_penable_i;
    assign w_wr        = w_access & r_pready & apb_pwrite_i;
    assign w_busy      = (r_state == S_CLIP) || (r_state == S_FILL);
    assign w_geom_addr = (apb_paddr_i == A_X0) || (apb_paddr_i == A_Y0) || (apb_paddr_i == A_W) ||
                         (apb_paddr_i == A_H)  || (apb_paddr_i == A_COLOR);
    // ABORT dominates START when both bits are written together.
    assign w_start_req = (apb_paddr_i == A_CTRL) & apb_pwdata_i[0] & ~apb_pwdata_i[1];
    assign w_start_ok  = w_wr & w_start_req & ~w_busy;
    assign w_abort_ok  = w_wr & (apb_paddr_i == A_CTRL) & apb_pwdata_i[1] & w_busy;

    // Clip arithmetic carries one extra bit so X0+WIDTH never wraps.
    assign w_xsum  = {1'b0, r_lx0} + {1'b0, r_lw};
    assign w_ysum  = {1'b0, r_ly0} + {1'b0, r_lh};
    assign w_xe    = (w_xsum > H_LIM) ? H_LIM : w_xsum;
    assign w_ye    = (w_ysum > V_LIM) ? V_LIM : w_ysum;
    assign w_empty = (r_lw == '0) || (r_lh == '0) || ({1'b0, r_lx0} >= H_LIM) || ({1'b0, r_ly0} >= V_LIM);

    assign w_xfer   = (r_state == S_FILL) & pix_ready_i;
    assign w_last_x = ({1'b0, r_cx} == r_xe - (COORD_W+1)'(1));
    assign w_last_y = ({1'b0, r_cy} == r_ye - (COORD_W+1)'(1));

`ifdef VGA_FILL_IRQ_EN
    logic r_irq_en;
    assign w_irq_clr = w_wr & (apb_paddr_i == APB_ADDR_WIDTH'('h1C)) & apb_pwdata_i[1];
    assign irq_o     = r_done & r_irq_en;
`else
    assign w_irq_clr = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_CLIP;
            S_CLIP: begin
                if (w_abort_ok)   w_state_nxt = S_IDLE;
                else if (w_empty) w_state_nxt = S_DONE;
                else              w_state_nxt = S_FILL;
            end
            S_FILL: begin
                if (w_abort_ok)                          w_state_nxt = S_IDLE;
                else if (w_xfer && w_last_x && w_last_y) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = w_start_ok ? S_CLIP : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (apb_paddr_i)
            A_X0:    w_rdata[COORD_W-1:0] = r_x0;
            A_Y0:    w_rdata[COORD_W-1:0] = r_y0;
            A_W:     w_rdata[COORD_W-1:0] = r_w;
            A_H:     w_rdata[COORD_W-1:0] = r_h;
            A_COLOR: w_rdata[COLOR_W-1:0] = r_color;
            A_CTRL:  w_rdata[1:0]         = {r_done, w_busy};
            A_COUNT: w_rdata[CNT_W-1:0]   = r_count;
`ifdef VGA_FILL_IRQ_EN
            APB_ADDR_WIDTH'('h1C): w_rdata[0] = r_irq_en;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pready <= 1'b0;
            r_x0 <= '0; r_y0 <= '0; r_w <= '0; r_h <= '0; r_color <= '0;
            r_lx0 <= '0; r_ly0 <= '0; r_lw <= '0; r_lh <= '0; r_lcolor <= '0;
            r_xe <= '0; r_ye <= '0; r_cx <= '0; r_cy <= '0;
            r_count <= '0;
            r_done <= 1'b0;
`ifdef VGA_FILL_IRQ_EN
            r_irq_en <= 1'b0;
`endif
        end else begin
            r_pready <= w_access & ~r_pready;
            if (w_wr && !w_busy) begin
                case (apb_paddr_i)
                    A_X0:    r_x0    <= apb_pwdata_i[COORD_W-1:0];
                    A_Y0:    r_y0    <= apb_pwdata_i[COORD_W-1:0];
                    A_W:     r_w     <= apb_pwdata_i[COORD_W-1:0];
                    A_H:     r_h     <= apb_pwdata_i[COORD_W-1:0];
                    A_COLOR: r_color <= apb_pwdata_i[COLOR_W-1:0];
                    default: ;
                endcase
            end
`ifdef VGA_FILL_IRQ_EN
            if (w_wr && apb_paddr_i == APB_ADDR_WIDTH'('h1C)) r_irq_en <= apb_pwdata_i[0];
`endif
            if (w_start_ok) begin
                r_lx0 <= r_x0; r_ly0 <= r_y0; r_lw <= r_w; r_lh <= r_h; r_lcolor <= r_color;
                r_count <= '0;
            end
            if (r_state == S_CLIP) begin
                r_xe <= w_xe; r_ye <= w_ye; r_cx <= r_lx0; r_cy <= r_ly0;
            end else if (w_xfer) begin
                r_count <= r_count + CNT_W'(1);
                if (w_last_x) begin
                    r_cx <= r_lx0;
                    r_cy <= r_cy + COORD_W'(1);
                end else begin
                    r_cx <= r_cx + COORD_W'(1);
                end
            end
            if (w_start_ok)              r_done <= 1'b0;
            else if (r_state == S_DONE)  r_done <= 1'b1;
            else if (w_irq_clr)          r_done <= 1'b0;
        end
    end

    assign apb_pready_o  = r_pready;
    assign apb_prdata_o  = r_pready ? w_rdata : '0;
    assign apb_pslverr_o = r_pready & apb_pwrite_i & w_busy & (w_geom_addr | w_start_req);
    assign busy_o        = w_busy;
    assign pix_we_o      = (r_state == S_FILL);
    assign pix_x_o       = pix_we_o ? r_cx : '0;
    assign pix_y_o       = pix_we_o ? r_cy : '0;
    assign pix_color_o   = pix_we_o ? r_lcolor : '0;
endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Self-checking bench for vga_fill_ctrl: randomized fills and ready stalls against a
// raster-order reference model built from clipped rectangle arithmetic.
`timescale 1ns/1ps
module tb_vga_fill_ctrl;
    localparam int H = 640;
    localparam int V = 480;
    localparam logic [11:0] A_X0 = 12'h00, A_Y0 = 12'h04, A_W = 12'h08, A_H = 12'h0C;
    localparam logic [11:0] A_COLOR = 12'h10, A_CTRL = 12'h14, A_COUNT = 12'h18, A_IRQ = 12'h1C;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  c;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;
    logic [10:0] pix_x, pix_y;
    logic [1:0]  pix_color;
    logic        pix_we, pix_ready, busy;
`ifdef VGA_FILL_IRQ_EN
    logic        irq;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 budgeted
    int   budget = 0;
    int   stall_viol = 0;
    pix_t obs_q[$];
    pix_t exp_q[$];
    int   stamp_q[$];
    pix_t prev_pix;
    logic prev_stall = 1'b0;

    vga_fill_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
        .apb_psel_i(psel), .apb_penable_i(penable),
        .apb_prdata_o(prdata), .apb_pready_o(pready), .apb_pslverr_o(pslverr),
        .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_color_o(pix_color),
        .pix_we_o(pix_we), .pix_ready_i(pix_ready),
`ifdef VGA_FILL_IRQ_EN
        .irq_o(irq),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            2:       pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = (budget > 0);
        endcase
    end

    // Pixel sink monitor: records every accepted write and any change while stalled.
    always @(negedge clk) begin
        if (pix_we && prev_stall && ({pix_x, pix_y, pix_color} != prev_pix)) stall_viol++;
        prev_stall = pix_we && !pix_ready;
        prev_pix   = {pix_x, pix_y, pix_color};
        if (pix_we && pix_ready) begin
            obs_q.push_back({pix_x, pix_y, pix_color});
            stamp_q.push_back(cyc);
            if (ready_mode == 3 && budget > 0) budget--;
        end
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err);
        int n;
        @(negedge clk);
        psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        n = 0;
        while (!pready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!pready) begin
            checks++; errors++;
            $display("FAIL apb_timeout addr=%0h got pready=0 expected 1", a);
        end
        rd  = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        logic [31:0] dummy;
        apb_xfer(1'b1, a, d, dummy, err);
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        apb_xfer(1'b0, a, 32'd0, d, err);
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h, input int c);
        logic e;
        apb_write(A_X0, 32'(x0), e);
        apb_write(A_Y0, 32'(y0), e);
        apb_write(A_W, 32'(w), e);
        apb_write(A_H, 32'(h), e);
        apb_write(A_COLOR, 32'(c), e);
    endtask

    // Reference model: clipped rectangle enumerated x inner, y outer.
    task automatic build_exp(input int x0, input int y0, input int w, input int h, input int c);
        int xe, ye;
        exp_q.delete();
        obs_q.delete();
        stamp_q.delete();
        if (w == 0 || h == 0 || x0 >= H || y0 >= V) return;
        xe = (x0 + w < H) ? x0 + w : H;
        ye = (y0 + h < V) ? y0 + h : V;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                exp_q.push_back({11'(x), 11'(y), 2'(c)});
    endtask

    function automatic int pix_diffs();
        int d;
        d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL fill_timeout got busy=1 expected 0 after %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic e;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_we, busy, pready, pslverr, prdata, pix_x, pix_y, pix_color} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h expected 0", {pix_we, busy, pready, pslverr, prdata, pix_x, pix_y, pix_color});
        end
        rst = 1'b0;
        apb_read(A_CTRL, rd, e);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %0h expected 0", rd); end
        apb_read(A_COUNT, rd, e);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_count got %0h expected 0", rd); end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic e;
        ready_mode = 0;
        program_rect(10, 20, 3, 2, 2);
        build_exp(10, 20, 3, 2, 2);
        apb_write(A_CTRL, 32'h1, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL basic_start_err got %0b expected 0", e); end
        checks++;
        if ({busy, pix_we} !== 2'b10) begin errors++; $display("FAIL basic_clip_cycle got busy,we=%b expected 10", {busy, pix_we}); end
        @(negedge clk);
        checks++;
        if ({pix_we, pix_x, pix_y, pix_color} !== {1'b1, 11'd10, 11'd20, 2'd2}) begin
            errors++;
            $display("FAIL basic_first_write got we=%0b x=%0d y=%0d c=%0d expected 1 10 20 2", pix_we, pix_x, pix_y, pix_color);
        end
        wait_idle(50);
        checks++;
        if (pix_diffs() !== 0) begin errors++; $display("FAIL basic_pixels got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        checks++;
        if (stamp_q.size() != 6 || stamp_q[stamp_q.size()-1] - stamp_q[0] !== 5) begin
            errors++; $display("FAIL basic_back_to_back got %0d transfers not consecutive expected 6 consecutive", stamp_q.size());
        end
        apb_read(A_CTRL, rd, e);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL basic_ctrl got %0h expected 2", rd); end
        apb_read(A_COUNT, rd, e);
        checks++;
        if (rd !== 32'd6) begin errors++; $display("FAIL basic_count got %0d expected 6", rd); end
    endtask

    task automatic test_clip();
        logic [31:0] rd;
        logic e;
        ready_mode = 0;
        program_rect(638, 479, 5, 4, 1);
        build_exp(638, 479, 5, 4, 1);
        apb_write(A_CTRL, 32'h1, e);
        wait_idle(50);
        checks++;
        if (pix_diffs() !== 0) begin errors++; $display("FAIL clip_pixels got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        apb_read(A_COUNT, rd, e);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL clip_count got %0d expected 2", rd); end
        apb_read(A_CTRL, rd, e);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL clip_ctrl got %0h expected 2", rd); end
    endtask

    task automatic test_empty();
        logic [31:0] rd;
        logic e;
        ready_mode = 0;
        program_rect(100, 100, 0, 5, 3);
        build_exp(100, 100, 0, 5, 3);
        apb_write(A_CTRL, 32'h1, e);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL empty_busy got %0b expected 1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_one_cycle got %0b expected 0", busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL empty_writes got %0d expected 0", obs_q.size()); end
        apb_read(A_CTRL, rd, e);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL empty_ctrl got %0h expected 2", rd); end
        apb_read(A_COUNT, rd, e);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL empty_count got %0d expected 0", rd); end
    endtask

    task automatic test_stall();
        logic e;
        ready_mode = 1;
        stall_viol = 0;
        program_rect(50, 60, 4, 1, 1);
        build_exp(50, 60, 4, 1, 1);
        apb_write(A_CTRL, 32'h1, e);
        wait_idle(64);
        checks++;
        if (pix_diffs() !== 0) begin errors++; $display("FAIL stall_pixels got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d changes expected 0", stall_viol); end
    endtask

    task automatic test_busy_abort();
        logic [31:0] rd;
        logic e;
        int n;
        ready_mode = 3;
        budget = 0;
        program_rect(5, 7, 20, 2, 3);
        build_exp(5, 7, 20, 2, 3);
        apb_write(A_CTRL, 32'h1, e);
        apb_write(A_X0, 32'd99, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL busy_write_err got %0b expected 1", e); end
        apb_write(A_CTRL, 32'h1, e);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL busy_start_err got %0b expected 1", e); end
        apb_read(A_X0, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 32'd5}) begin errors++; $display("FAIL busy_x0_kept got %0d err %0b expected 5 err 0", rd, e); end
        budget = 3;
        n = 0;
        while (obs_q.size() < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        apb_write(A_CTRL, 32'h2, e);
        checks++;
        if ({e, busy, pix_we} !== 3'b000) begin errors++; $display("FAIL abort_idle got err,busy,we=%b expected 000", {e, busy, pix_we}); end
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        checks++;
        if (pix_diffs() !== 0) begin errors++; $display("FAIL abort_pixels got %0d writes expected 3", obs_q.size()); end
        apb_read(A_CTRL, rd, e);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL abort_ctrl got %0h expected 0", rd); end
        apb_read(A_COUNT, rd, e);
        checks++;
        if (rd !== 32'd3) begin errors++; $display("FAIL abort_count got %0d expected 3", rd); end
    endtask

    task automatic test_regs_unmapped();
        logic [31:0] rd;
        logic e;
        ready_mode = 0;
        program_rect(1, 1, 1, 1, 1);
        apb_write(A_CTRL, 32'h1, e);
        wait_idle(20);
        apb_write(A_CTRL, 32'h2, e);
        apb_read(A_CTRL, rd, e);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL idle_abort_ctrl got %0h expected 2", rd); end
        apb_write(A_CTRL, 32'h3, e);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins got busy=%0b expected 0", busy); end
        apb_write(A_X0, 32'hFFFF_FFFF, e);
        apb_read(A_X0, rd, e);
        checks++;
        if (rd !== 32'h7FF) begin errors++; $display("FAIL x0_width got %0h expected 7ff", rd); end
        apb_write(A_COLOR, 32'hFFFF_FFFF, e);
        apb_read(A_COLOR, rd, e);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL color_width got %0h expected 3", rd); end
        apb_write(12'h20, 32'h1234, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL unmapped_write_err got %0b expected 0", e); end
        apb_read(12'h20, rd, e);
        checks++;
        if ({e, rd} !== 33'd0) begin errors++; $display("FAIL unmapped_read got %0h err %0b expected 0", rd, e); end
`ifndef VGA_FILL_IRQ_EN
        apb_read(A_IRQ, rd, e);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL irq_reg_unmapped got %0h expected 0", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic e;
        int x0, y0, w, h, c;
        ready_mode = 2;
        for (int it = 0; it < 12; it++) begin
            x0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, H - 1));
            y0 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, V - 1));
            w  = $urandom_range(0, 9);
            h  = $urandom_range(0, 5);
            c  = $urandom_range(0, 3);
            program_rect(x0, y0, w, h, c);
            build_exp(x0, y0, w, h, c);
            apb_write(A_CTRL, 32'h1, e);
            wait_idle(400);
            checks++;
            if (pix_diffs() !== 0) begin
                errors++;
                $display("FAIL random_pixels it=%0d got %0d writes expected %0d (x0=%0d y0=%0d w=%0d h=%0d)", it, obs_q.size(), exp_q.size(), x0, y0, w, h);
            end
            apb_read(A_COUNT, rd, e);
            checks++;
            if (rd !== 32'(exp_q.size())) begin errors++; $display("FAIL random_count it=%0d got %0d expected %0d", it, rd, exp_q.size()); end
        end
    endtask

    task automatic test_reset_midfill();
        logic [31:0] rd;
        logic e;
        ready_mode = 3;
        budget = 0;
        program_rect(0, 0, 8, 8, 1);
        apb_write(A_CTRL, 32'h1, e);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pix_we, busy, pix_x, pix_y, pix_color} !== '0) begin
            errors++; $display("FAIL async_reset got we=%0b busy=%0b expected 0 0", pix_we, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        apb_read(A_X0, rd, e);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_x0 got %0d expected 0", rd); end
    endtask

`ifdef VGA_FILL_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        logic e;
        ready_mode = 0;
        apb_write(A_IRQ, 32'h1, e);
        program_rect(3, 3, 1, 1, 2);
        apb_write(A_CTRL, 32'h1, e);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared_by_start got %0b expected 0", irq); end
        wait_idle(20);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_in_done got %0b expected 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %0b expected 1", irq); end
        apb_write(A_IRQ, 32'h3, e);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %0b expected 0", irq); end
        apb_read(A_IRQ, rd, e);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL irq_enable_rb got %0h expected 1", rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_stall();
        test_busy_abort();
        test_regs_unmapped();
        test_random();
`ifdef VGA_FILL_IRQ_EN
        test_irq();
`endif
        test_reset_midfill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
